// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D cache memory arbiter.
// Optional build macro used by this block: ARB_ROUND_ROBIN_EN.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cache_arbiter_grant.sv
// Grant selection between I-side and D-side requests.
// ARB_ROUND_ROBIN_EN defined: contention goes to the side not granted last.
// ARB_ROUND_ROBIN_EN undefined: D-side always wins contention.
module arbiter_grant (
  input  logic last_grant,  // 1 = D-side held the most recent grant
  input  logic i_req,
  input  logic d_req,
  output logic grant_d,
  output logic grant_i
);

`ifdef ARB_ROUND_ROBIN_EN
  // On contention, hand the grant to the side that waited last time
  always_comb begin
    grant_d = d_req && (!i_req || !last_grant);
    grant_i = i_req && (!d_req || last_grant);
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Fixed priority: D-side first
  always_comb begin
    grant_d = d_req;
    grant_i = i_req && !d_req;
  end
`endif

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one memory port.
// Optional build macro: ARB_ROUND_ROBIN_EN (round-robin instead of D-first).
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        state;
  arb_state_t        state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              read_q;
  logic              write_q;
  logic              d_req;
  logic              grant_d;
  logic              grant_i;
  logic              last_d;

  assign d_req = d_read || d_write;

  arbiter_grant u_grant (
    .last_grant (last_d),
    .i_req      (i_read),
    .d_req      (d_req),
    .grant_d    (grant_d),
    .grant_i    (grant_i)
  );

`ifdef ARB_ROUND_ROBIN_EN
  // Remember the side granted last; reset leaves priority with the D-side
  always_ff @(posedge clk) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (state == IDLE && (grant_d || grant_i)) begin
      last_d <= grant_d;
    end
  end
`else
  assign last_d = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_next = D_BUSY;
        end else if (grant_i) begin
          state_next = I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (pmem_resp) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Latch the granted request; memory-side outputs come only from here
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else if (state == IDLE) begin
      if (grant_d) begin
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
        write_q <= d_write;
        read_q  <= !d_write;
      end else if (grant_i) begin
        addr_q  <= i_addr;
        wdata_q <= '0;
        write_q <= 1'b0;
        read_q  <= 1'b1;
      end
    end else if (pmem_resp) begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end
  end

  assign pmem_read    = read_q;
  assign pmem_write   = write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  // Completion is steered to the owning side in the memory response cycle
  assign i_resp  = (state == I_BUSY) && pmem_resp && !rst;
  assign d_resp  = (state == D_BUSY) && pmem_resp && !rst;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: memory responder + scoreboard.
// Build with ARB_ROUND_ROBIN_EN defined to check the round-robin variant.
module tb_cache_arbiter;

  localparam int unsigned LW = 256;
  localparam int unsigned AW = 32;

  typedef struct {
    bit             wr;
    bit             rd_too;
    logic [AW-1:0]  addr;
    logic [LW-1:0]  wdata;
  } req_t;

  typedef struct {
    bit             is_d;
    bit             wr;
    logic [AW-1:0]  addr;
    logic [LW-1:0]  wdata;
    logic [LW-1:0]  rdata;
    int             lat;
    int             gap;
    bit             req_chk;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  logic          resp_m = 1'b0;
  logic [LW-1:0] rdata_m = '0;
  logic          resp_t = 1'b0;
  logic [LW-1:0] rdata_t = '0;

  assign pmem_resp  = resp_m || resp_t;
  assign pmem_rdata = resp_t ? rdata_t : rdata_m;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int start_cnt = 0;
  int start_cnt_i = 0;
  int start_cnt_d = 0;
  int seen_i = 0;
  int seen_d = 0;
  int raise_cyc_i = 0;
  int raise_cyc_d = 0;
  int last_resp_cyc = 0;
  bit had_resp = 0;
  bit mem_en = 1;
  bit active = 0;
  bit resp_out = 0;
  bit i_on = 0;
  bit d_on = 0;
  int lat_left = 0;
  exp_t cur;

  req_t iq[$];
  req_t dq[$];
  exp_t sb[$];

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_addr       (i_addr),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  // Memory model: check each transaction against the scoreboard head, answer after cur.lat cycles
  always @(negedge clk) begin
    cyc++;
    if (resp_out) begin
      resp_m   = 1'b0;
      resp_out = 0;
      active   = 0;
      done_cnt++;
      total++;
      if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || i_resp !== 1'b0 || d_resp !== 1'b0) begin
        bad++;
        $display("FAIL idle_after_resp got rd=%b wr=%b iresp=%b dresp=%b exp all 0",
                 pmem_read, pmem_write, i_resp, d_resp);
      end
    end else if (active) begin
      total++;
      if (pmem_address !== cur.addr || pmem_read !== !cur.wr || pmem_write !== cur.wr ||
          (cur.wr && pmem_wdata !== cur.wdata) || i_resp !== 1'b0 || d_resp !== 1'b0) begin
        bad++;
        $display("FAIL hold_stable got addr=%h rd=%b wr=%b iresp=%b dresp=%b exp addr=%h wr=%b resps 0",
                 pmem_address, pmem_read, pmem_write, i_resp, d_resp, cur.addr, cur.wr);
      end
      if (lat_left == 0) respond();
      else lat_left--;
    end else if (mem_en && (pmem_read === 1'b1 || pmem_write === 1'b1)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_txn got addr=%h exp no transaction", pmem_address);
      end else begin
        cur = sb.pop_front();
        if (pmem_address !== cur.addr || pmem_read !== !cur.wr || pmem_write !== cur.wr ||
            (cur.wr && pmem_wdata !== cur.wdata)) begin
          bad++;
          $display("FAIL txn_start got addr=%h rd=%b wr=%b exp addr=%h wr=%b",
                   pmem_address, pmem_read, pmem_write, cur.addr, cur.wr);
        end
        if (cur.gap != 0) begin
          total++;
          if (cyc - last_resp_cyc != cur.gap) begin
            bad++;
            $display("FAIL txn_gap got %0d exp %0d", cyc - last_resp_cyc, cur.gap);
          end
        end else if (had_resp) begin
          total++;
          if (cyc - last_resp_cyc < 2) begin
            bad++;
            $display("FAIL idle_gap got %0d exp >=2", cyc - last_resp_cyc);
          end
        end
        if (cur.req_chk) begin
          total++;
          if (cyc - (cur.is_d ? raise_cyc_d : raise_cyc_i) != 1) begin
            bad++;
            $display("FAIL req_latency got %0d exp 1", cyc - (cur.is_d ? raise_cyc_d : raise_cyc_i));
          end
        end
        active   = 1;
        lat_left = cur.lat;
        start_cnt++;
        if (cur.is_d) start_cnt_d++;
        else start_cnt_i++;
        if (lat_left == 0) respond();
        else lat_left--;
      end
    end
  end

  task automatic respond();
    resp_m  = 1'b1;
    rdata_m = cur.rdata;
    #1;
    total++;
    if (cur.is_d) begin
      if (d_resp !== 1'b1 || i_resp !== 1'b0 || (!cur.wr && d_rdata !== cur.rdata)) begin
        bad++;
        $display("FAIL d_completion got dresp=%b iresp=%b rdata=%h exp dresp=1 iresp=0 rdata=%h",
                 d_resp, i_resp, d_rdata[63:0], cur.rdata[63:0]);
      end
    end else begin
      if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== cur.rdata) begin
        bad++;
        $display("FAIL i_completion got iresp=%b dresp=%b rdata=%h exp iresp=1 dresp=0 rdata=%h",
                 i_resp, d_resp, i_rdata[63:0], cur.rdata[63:0]);
      end
    end
    resp_out      = 1;
    last_resp_cyc = cyc;
    had_resp      = 1;
  endtask

  task automatic add_txn(input bit is_d, input bit wr, input bit rd_too, input logic [AW-1:0] addr,
                         input logic [LW-1:0] wdata, input logic [LW-1:0] rdata,
                         input int lat, input int gap, input bit req_chk);
    req_t r;
    exp_t e;
    r.wr = wr; r.rd_too = rd_too; r.addr = addr; r.wdata = wdata;
    if (is_d) dq.push_back(r);
    else iq.push_back(r);
    e.is_d = is_d; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    e.lat = lat; e.gap = gap; e.req_chk = req_chk;
    sb.push_back(e);
  endtask

  // Hold each side's queue head on its request port until the memory model sees it start
  task automatic drive_step();
    if (start_cnt_i != seen_i) begin
      if (iq.size() > 0) void'(iq.pop_front());
      seen_i = start_cnt_i;
      i_on = 0;
    end
    if (start_cnt_d != seen_d) begin
      if (dq.size() > 0) void'(dq.pop_front());
      seen_d = start_cnt_d;
      d_on = 0;
    end
    if (iq.size() > 0) begin
      if (!i_on) begin raise_cyc_i = cyc; i_on = 1; end
      i_read = 1'b1;
      i_addr = iq[0].addr;
    end else begin
      i_read = 1'b0;
      i_addr = $urandom();
    end
    if (dq.size() > 0) begin
      if (!d_on) begin raise_cyc_d = cyc; d_on = 1; end
      d_write = dq[0].wr;
      d_read  = !dq[0].wr || dq[0].rd_too;
      d_addr  = dq[0].addr;
      d_wdata = dq[0].wdata;
    end else begin
      d_write = 1'b0;
      d_read  = 1'b0;
      d_addr  = $urandom();
      d_wdata = rnd_line();
    end
  endtask

  task automatic run_until(input int done_t, input int start_t, input int budget, input string nm);
    int n = 0;
    while ((done_cnt < done_t || start_cnt < start_t) && n < budget) begin
      drive_step();
      @(negedge clk);
      #2;
      n++;
    end
    drive_step();
    total++;
    if (done_cnt < done_t || start_cnt < start_t) begin
      bad++;
      $display("FAIL %s_timeout got done=%0d start=%0d exp done=%0d start=%0d",
               nm, done_cnt, start_cnt, done_t, start_t);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || i_resp !== 1'b0 || d_resp !== 1'b0 ||
          pmem_address !== '0 || pmem_wdata !== '0) begin
        bad++;
        $display("FAIL reset_state got rd=%b wr=%b iresp=%b dresp=%b addr=%h exp all 0",
                 pmem_read, pmem_write, i_resp, d_resp, pmem_address);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    #2;
  endtask

  task automatic test_i_fill();
    logic [LW-1:0] a5;
    a5 = {32{8'hA5}};
    add_txn(0, 0, 0, 32'h0000_0040, '0, a5, 5, 0, 1);
    run_until(done_cnt + 1, 0, 40, "i_fill");
  endtask

  task automatic test_d_writeback();
    logic [LW-1:0] dead;
    dead = {16{16'hDEAD}};
    add_txn(1, 1, 0, 32'h0000_1000, dead, rnd_line(), 2, 0, 1);
    run_until(done_cnt + 1, 0, 40, "d_wb");
    add_txn(1, 1, 1, 32'h0000_2000, rnd_line(), rnd_line(), 0, 0, 1);
    run_until(done_cnt + 1, 0, 40, "d_rdwr");
    add_txn(1, 0, 0, 32'h0000_3000, '0, rnd_line(), 1, 0, 1);
    run_until(done_cnt + 1, 0, 40, "d_read");
  endtask

  task automatic test_contention();
    reset_dut();
    add_txn(1, 0, 0, 32'h0000_4000, '0, rnd_line(), 2, 0, 1);
`ifdef ARB_ROUND_ROBIN_EN
    add_txn(0, 0, 0, 32'h0000_5000, '0, rnd_line(), 2, 2, 0);
    add_txn(1, 0, 0, 32'h0000_4040, '0, rnd_line(), 2, 2, 0);
`else
    add_txn(1, 0, 0, 32'h0000_4040, '0, rnd_line(), 2, 2, 0);
    add_txn(0, 0, 0, 32'h0000_5000, '0, rnd_line(), 2, 2, 0);
`endif
    run_until(done_cnt + 3, 0, 80, "contention");
  endtask

  task automatic test_wait_mid();
    add_txn(1, 0, 0, 32'h0000_6000, '0, rnd_line(), 4, 0, 1);
    run_until(0, start_cnt + 1, 40, "mid_dstart");
    add_txn(0, 0, 0, 32'h0000_7000, '0, rnd_line(), 1, 2, 0);
    run_until(done_cnt + 2, 0, 60, "mid_wait");
  endtask

  task automatic test_reset_mid();
    mem_en = 0;
    @(negedge clk);
    #2;
    i_read = 1'b1;
    i_addr = 32'h0000_0080;
    @(negedge clk);
    total++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_0080) begin
      bad++;
      $display("FAIL rstmid_start got rd=%b addr=%h exp rd=1 addr=00000080", pmem_read, pmem_address);
    end
    #2;
    i_read = 1'b0;
    i_addr = 32'h0000_0999;
    rdata_t = rnd_line();
    resp_t = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    resp_t = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || i_resp !== 1'b0 || d_resp !== 1'b0 ||
        pmem_address !== '0) begin
      bad++;
      $display("FAIL rstmid_after got rd=%b wr=%b iresp=%b dresp=%b addr=%h exp all 0",
               pmem_read, pmem_write, i_resp, d_resp, pmem_address);
    end
    @(negedge clk);
    resp_t = 1'b1;
    #1;
    total++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
      bad++;
      $display("FAIL idle_resp_ignored got iresp=%b dresp=%b exp 0 0", i_resp, d_resp);
    end
    @(negedge clk);
    resp_t = 1'b0;
    #1;
    total++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_stray got rd=%b wr=%b exp 0 0", pmem_read, pmem_write);
    end
    mem_en = 1;
    #1;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++)
      add_txn(1, k[0], 0, 32'h0001_0000 + 32'(k * 64), rnd_line(), rnd_line(),
              $urandom_range(0, 3), (k == 0) ? 0 : 2, k == 0);
    run_until(done_cnt + 3, 0, 80, "b2b_d");
    for (int k = 0; k < 3; k++)
      add_txn(0, 0, 0, 32'h0002_0000 + 32'(k * 64), '0, rnd_line(),
              $urandom_range(0, 3), (k == 0) ? 0 : 2, k == 0);
    run_until(done_cnt + 3, 0, 80, "b2b_i");
  endtask

  initial begin
    test_reset();
    test_i_fill();
    test_d_writeback();
    test_contention();
    test_wait_mid();
    test_reset_mid();
    @(negedge clk);
    #2;
    test_back_to_back();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got %0d left exp 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
